fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequential instruction fetch front-end in front of a
// combinational 2^14 x 32-bit instruction ROM. It delivers one instruction per
// cycle through a valid/ready slot and supports redirects (branch/jump), halt
// and resume.
//
// Optional feature: `FETCH_SEQ_ALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned target enters FAULT. FAULT is
//               left only through rst.
//   undefined : there is no FAULT state, fault is tied to 0, and the low two
//               bits of redirect_pc are dropped.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           level: start/resume fetching from IDLE or HALT
//   halt_req        level: stop once the pending output instruction is gone
//   redirect_valid  one-cycle strobe that loads redirect_pc into the PC
//   redirect_pc     redirect target byte address
//   rom_addr        ROM word address, always pc[15:2]
//   rom_data        ROM word for rom_addr, same cycle
//   inst, inst_pc   registered instruction and its byte address
//   inst_valid      output slot occupied
//   inst_ready      decode accepts; a transfer is inst_valid && inst_ready
//   busy            1 in RUN
//   fault           1 in FAULT
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [13:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
`ifdef FETCH_SEQ_ALIGN_CHK_EN
    , FAULT
`endif
  } state_t;

  state_t      state;
  logic [15:0] pc;

  // The slot can take a new word when it is empty or being drained this cycle.
  logic        slot_free;
  logic [15:0] redir_tgt;

  assign slot_free = !inst_valid || inst_ready;
  assign redir_tgt = redirect_pc & 16'hFFFC;
  assign rom_addr  = pc[15:2];
  assign busy      = (state == RUN);
`ifdef FETCH_SEQ_ALIGN_CHK_EN
  assign fault     = (state == FAULT);
`else
  assign fault     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_pc    <= 16'h0;
      inst_valid <= 1'b0;
    end else begin
`ifdef FETCH_SEQ_ALIGN_CHK_EN
      if (state == FAULT) begin
        inst_valid <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        // Misaligned target: PC keeps its old value for post-mortem.
        state      <= FAULT;
        inst_valid <= 1'b0;
      end else
`endif
      if (redirect_valid) begin
        // Redirect wins over everything: flush the slot, no fetch this cycle.
        pc         <= redir_tgt;
        inst_valid <= 1'b0;
        if (state == RUN && halt_req) state <= HALT;
      end else begin
        unique case (state)
          IDLE: if (start) state <= RUN;
          HALT: if (start && !halt_req) state <= RUN;
          RUN: begin
            if (slot_free) begin
              if (halt_req) begin
                state      <= HALT;
                inst_valid <= 1'b0;
              end else begin
                inst       <= rom_data;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc + 16'd4;  // wraps modulo 2^16
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed stimulus; expected instruction addresses
// are pushed into a queue and a negedge monitor checks every transfer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        busy;
  logic        fault;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // ROM contents: word w holds 32'h1000_0000 + w.
  assign rom_data = 32'h1000_0000 + {18'h0, rom_addr};

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .busy(busy), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the next expected address.
  always @(negedge clk) begin
    if (!rst && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL xfer_unexpected: got inst_pc %h, none expected", inst_pc);
      end else begin
        logic [15:0] e;
        logic [31:0] ei;
        e  = exp_q.pop_front();
        ei = 32'h1000_0000 + {18'h0, e[15:2]};
        check("xfer_inst_pc", {16'h0, inst_pc}, {16'h0, e});
        check("xfer_inst", inst, ei);
      end
    end
  end

  initial begin
    // Reset
    tick(); tick();
    check("rst_valid", {31'h0, inst_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_fault", {31'h0, fault}, 32'd0);
    check("rst_rom_addr", {18'h0, rom_addr}, 32'd0);
    check("rst_inst", inst, 32'h0);
    rst = 1'b0;

    // Sequential fetch with a 3-cycle stall
    foreach (exp_q[i]) ; // no-op
    for (int a = 0; a <= 16'h10; a += 4) exp_q.push_back(16'(a));
    start = 1'b1; inst_ready = 1'b1;
    tick();
    check("start_busy", {31'h0, busy}, 32'd1);
    check("start_no_fetch", {31'h0, inst_valid}, 32'd0);
    start = 1'b0;
    tick();
    check("first_fetch_pc", {16'h0, inst_pc}, 32'h0);
    check("first_rom_addr", {18'h0, rom_addr}, 32'd1);
    repeat (3) tick();               // inst_pc 0xC shown
    inst_ready = 1'b0;
    repeat (3) begin
      tick();
      check("stall_inst_pc", {16'h0, inst_pc}, 32'h000C);
      check("stall_valid", {31'h0, inst_valid}, 32'd1);
      check("stall_rom_addr", {18'h0, rom_addr}, 32'd4);
    end
    inst_ready = 1'b1;
    repeat (2) tick();               // 0x14 shown, 0x10 consumed

    // Redirect flush (shown 0x14 is dropped)
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    exp_q.push_back(16'h0100);
    tick();
    check("redir_flush_valid", {31'h0, inst_valid}, 32'd0);
    check("redir_rom_addr", {18'h0, rom_addr}, 32'h40);
    redirect_valid = 1'b0; inst_ready = 1'b1;
    tick();
    check("redir_inst_pc", {16'h0, inst_pc}, 32'h0100);
    check("redir_valid", {31'h0, inst_valid}, 32'd1);
    tick();                          // 0x100 consumed, 0x104 shown

    // Redirect near top of address space, PC wraps
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
    exp_q.push_back(16'hFFF8); exp_q.push_back(16'hFFFC);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0004);
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (3) tick();
    check("wrap_inst_pc", {16'h0, inst_pc}, 32'h0000);
    tick();                          // 0x0004 shown

    // Halt with stalled decode
    inst_ready = 1'b0; halt_req = 1'b1;
    tick();
    check("halt_hold_pc", {16'h0, inst_pc}, 32'h0004);
    check("halt_hold_busy", {31'h0, busy}, 32'd1);
    check("halt_no_fetch", {18'h0, rom_addr}, 32'd2);
    inst_ready = 1'b1;
    tick();
    check("halt_busy", {31'h0, busy}, 32'd0);
    check("halt_valid", {31'h0, inst_valid}, 32'd0);
    start = 1'b1;                    // start with halt_req still set
    tick();
    check("halt_start_blocked", {31'h0, busy}, 32'd0);
    halt_req = 1'b0;
    exp_q.push_back(16'h0008);
    tick();
    check("resume_busy", {31'h0, busy}, 32'd1);
    start = 1'b0;
    tick();
    check("resume_pc", {16'h0, inst_pc}, 32'h0008);
    tick();                          // 0x8 consumed, 0xC shown

    // Reset mid-operation
    inst_ready = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'h0, inst_valid}, 32'd0);
    check("mid_rst_pc", {16'h0, inst_pc}, 32'h0);
    check("mid_rst_inst", inst, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_rom_addr", {18'h0, rom_addr}, 32'd0);
    rst = 1'b0;

    // Misaligned redirect in IDLE
    redirect_valid = 1'b1; redirect_pc = 16'h0102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_SEQ_ALIGN_CHK_EN
    check("align_fault", {31'h0, fault}, 32'd1);
    check("align_pc_kept", {18'h0, rom_addr}, 32'd0);
    start = 1'b1;
    tick();
    check("fault_start_ignored", {31'h0, busy}, 32'd0);
    check("fault_valid", {31'h0, inst_valid}, 32'd0);
    start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fault_cleared", {31'h0, fault}, 32'd0);
`else
    check("align_ignored_fault", {31'h0, fault}, 32'd0);
    check("idle_redir_rom_addr", {18'h0, rom_addr}, 32'h40);
    check("idle_redir_state", {31'h0, busy}, 32'd0);
`endif

    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
